// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each bit period.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic bit_tick
);

  localparam int            CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_tick = en && (cnt_q == LAST);

  // Next count: clear has priority, otherwise advance and wrap at the bit boundary.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = bit_tick ? '0 : cnt_q + CW'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a synchronous FIFO and sends each as an 8N1 UART frame.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | line high, waiting for enable with a non-empty FIFO
// ST_READ  | one-cycle pop pulse to the FIFO
// ST_WAIT  | FIFO output valid, loaded into the shift register
// ST_START | start bit (low) for one bit period
// ST_DATA  | eight data bits, LSB first
// ST_STOP  | stop bit (high); frame_done on its final cycle
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 fifo_empty,
  output logic                 fifo_rd,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 txd,
  output logic                 busy,
  output logic                 frame_done
);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("fifo_uart_tx: CLKS_PER_BIT must be at least 2");
  end

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 baud_clr, baud_en, bit_tick;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clr     (baud_clr),
    .en      (baud_en),
    .bit_tick(bit_tick)
  );

  // Next-state and Moore output decode; the FIFO is only looked at in idle,
  // so a frame in flight can never cause an underflow.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    fifo_rd    = 1'b0;
    txd        = IDLE_LEVEL;
    busy       = 1'b1;
    frame_done = 1'b0;
    baud_clr   = 1'b0;
    baud_en    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (enable && !fifo_empty) state_d = ST_READ;
      end
      ST_READ: begin
        fifo_rd = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        shift_d  = fifo_data;
        baud_clr = 1'b1;
        state_d  = ST_START;
      end
      ST_START: begin
        txd     = 1'b0;
        baud_en = 1'b1;
        if (bit_tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        txd     = shift_q[0];
        baud_en = 1'b1;
        if (bit_tick) begin
          shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST_BIT) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        baud_en = 1'b1;
        if (bit_tick) begin
          frame_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, shift register and bit counter with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx with a behavioural FIFO in front and a scoreboard
// of bytes that are expected to appear on the serial line.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       fifo_empty;
  logic       fifo_rd;
  logic [7:0] fifo_data = 8'h00;
  logic       txd;
  logic       busy;
  logic       frame_done;

  logic [7:0] mem [256];
  logic [7:0] wptr = 8'd0;
  logic [7:0] rptr = 8'd0;
  logic [7:0] exp_q [$];

  int cyc      = 0;
  int rd_cnt   = 0;
  int done_cnt = 0;
  int n_cmp    = 0;
  int n_fail   = 0;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .fifo_empty(fifo_empty),
    .fifo_rd   (fifo_rd),
    .fifo_data (fifo_data),
    .txd       (txd),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wptr == rptr);

  // FIFO read port: data appears the cycle after the pop.
  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_data <= mem[rptr];
      rptr      <= rptr + 8'd1;
    end
  end

  // Cycle count and pulse counters.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd)    rd_cnt   <= rd_cnt + 1;
    if (frame_done) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wptr] = b;
    wptr = wptr + 8'd1;
    exp_q.push_back(b);
  endtask

  task automatic wait_start(input int lim, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (txd === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Follows one frame cycle by cycle against the ideal 8N1 waveform of the
  // next scoreboard byte. drop_k: bit index at which enable is released.
  // abort_k: bit index at which reset is pulsed, ending the frame early.
  task automatic do_frame(input string tag, input int drop_k, input int abort_k,
                          output int start_cyc);
    logic [7:0] b;
    logic [9:0] fr;
    logic       ok;
    start_cyc = -1;
    check({tag, " scoreboard_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() == 0) return;
    b  = exp_q.pop_front();
    fr = {1'b1, b, 1'b0};
    wait_start(200, ok);
    check({tag, " start_seen"}, 32'(ok), 32'd1);
    if (!ok) return;
    start_cyc = cyc;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < CPB; c++) begin
        if (k == abort_k && c == 1) begin
          rst = 1'b1;
          tick();
          check({tag, " abort_txd"},  32'(txd),  32'd1);
          check({tag, " abort_busy"}, 32'(busy), 32'd0);
          rst = 1'b0;
          return;
        end
        if (k == drop_k && c == 0) enable = 1'b0;
        check($sformatf("%s txd bit%0d cyc%0d", tag, k, c), 32'(txd), 32'(fr[k]));
        check($sformatf("%s done bit%0d cyc%0d", tag, k, c), 32'(frame_done),
              32'(k == 9 && c == CPB - 1));
        check($sformatf("%s busy bit%0d", tag, k), 32'(busy), 32'd1);
        tick();
      end
    end
  endtask

  initial begin
    int rd_base, done_base, sc, prev_sc;

    // Reset held for five cycles, then one cycle after release.
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst txd",  32'(txd),     32'd1);
      check("rst busy", 32'(busy),    32'd0);
      check("rst rd",   32'(fifo_rd), 32'd0);
    end
    rst = 1'b0;
    tick();
    check("post_rst txd",  32'(txd),     32'd1);
    check("post_rst busy", 32'(busy),    32'd0);
    check("post_rst rd",   32'(fifo_rd), 32'd0);

    // Empty FIFO with enable high: nothing happens.
    enable  = 1'b1;
    rd_base = rd_cnt;
    for (int i = 0; i < 200; i++) begin
      tick();
      check("empty txd", 32'(txd),     32'd1);
      check("empty rd",  32'(fifo_rd), 32'd0);
    end
    check("empty rd_count", 32'(rd_cnt - rd_base), 32'd0);

    // Single byte 0xA5 with latency checks.
    rd_base   = rd_cnt;
    done_base = done_cnt;
    push(8'hA5);
    tick();
    check("A5 rd_latency", 32'(fifo_rd), 32'd1);
    tick();
    check("A5 rd_single", 32'(fifo_rd), 32'd0);
    check("A5 pre_start_txd", 32'(txd), 32'd1);
    tick();
    check("A5 start_latency", 32'(txd), 32'd0);
    do_frame("A5", -1, -1, sc);
    for (int i = 0; i < 5; i++) tick();
    check("A5 rd_count",   32'(rd_cnt - rd_base),     32'd1);
    check("A5 done_count", 32'(done_cnt - done_base), 32'd1);

    // Sixteen back-to-back bytes 0x00..0x0F.
    rd_base   = rd_cnt;
    done_base = done_cnt;
    for (int i = 0; i < 16; i++) push(8'(i));
    prev_sc = -1;
    for (int i = 0; i < 16; i++) begin
      do_frame($sformatf("B%0d", i), -1, -1, sc);
      if (prev_sc >= 0 && sc >= 0) check($sformatf("B%0d spacing", i), 32'(sc - prev_sc), 32'd43);
      prev_sc = sc;
    end
    tick();
    check("B busy_after",  32'(busy),                  32'd0);
    check("B fifo_empty",  32'(fifo_empty),            32'd1);
    check("B rd_count",    32'(rd_cnt - rd_base),      32'd16);
    check("B done_count",  32'(done_cnt - done_base),  32'd16);

    // Enable released mid-frame with three bytes queued.
    rd_base = rd_cnt;
    for (int i = 0; i < 3; i++) push(8'($urandom_range(0, 255)));
    do_frame("C0", 3, -1, sc);
    for (int i = 0; i < 30; i++) begin
      check("C paused rd",  32'(fifo_rd), 32'd0);
      check("C paused txd", 32'(txd),     32'd1);
      tick();
    end
    check("C paused rd_count", 32'(rd_cnt - rd_base), 32'd1);
    enable = 1'b1;
    do_frame("C1", -1, -1, sc);
    do_frame("C2", -1, -1, sc);
    tick();
    check("C rd_count", 32'(rd_cnt - rd_base), 32'd3);

    // Reset pulsed during data bit 3; the popped byte is lost.
    rd_base = rd_cnt;
    push(8'($urandom_range(0, 255)));
    push(8'($urandom_range(0, 255)));
    do_frame("D0", -1, 4, sc);
    do_frame("D1", -1, -1, sc);
    tick();
    check("D rd_count", 32'(rd_cnt - rd_base), 32'd2);

    // Random bytes.
    rd_base = rd_cnt;
    for (int i = 0; i < 5; i++) push(8'($urandom));
    for (int i = 0; i < 5; i++) do_frame($sformatf("R%0d", i), -1, -1, sc);
    tick();
    check("R rd_count", 32'(rd_cnt - rd_base), 32'd5);
    check("R idle_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
